// File: rtl/vector_writeback_assembler_if.sv
// Writeback bus between the execute/load units and the vector register file
// write port. The master side drives ALU results and lane-serial load beats;
// the slave side (the assembler) returns stall/status and the registered
// we3/ra3/wd3 write. Bypass signals exist only when VWB_BYPASS_EN is defined.
interface vector_writeback_assembler_if #(
  parameter int REGSIZEINT    = 4,
  parameter int VECTORSPERREG = 4,
  parameter int DATAWIDTH     = 16
);
  logic                                      alu_valid;
  logic [REGSIZEINT-1:0]                     alu_rd;
  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]   alu_data;
  logic                                      alu_stall;
  logic                                      ld_start;
  logic [REGSIZEINT-1:0]                     ld_rd;
  logic                                      ld_valid;
  logic [DATAWIDTH-1:0]                      ld_data;
  logic                                      ld_abort;
  logic                                      ld_busy;
  logic                                      ld_done;
  logic                                      err;
  logic                                      we3;
  logic [REGSIZEINT-1:0]                     ra3;
  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]   wd3;
`ifdef VWB_BYPASS_EN
  logic                                      byp_valid;
  logic [REGSIZEINT-1:0]                     byp_rd;
  logic [VECTORSPERREG-1:0][DATAWIDTH-1:0]   byp_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, ld_start, ld_rd, ld_valid, ld_data, ld_abort,
    input  alu_stall, ld_busy, ld_done, err, we3, ra3, wd3
`ifdef VWB_BYPASS_EN
    , input byp_valid, byp_rd, byp_data
`endif
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_start, ld_rd, ld_valid, ld_data, ld_abort,
    output alu_stall, ld_busy, ld_done, err, we3, ra3, wd3
`ifdef VWB_BYPASS_EN
    , output byp_valid, byp_rd, byp_data
`endif
  );
endinterface

// File: rtl/vector_writeback_assembler.sv
// Vector writeback assembler: merges single-beat ALU results and lane-serial
// memory loads into one registered register-file write (we3/ra3/wd3).
// Load lanes arrive lane 0 first and are collected in an assembly buffer; the
// final lane is merged directly from the bus so the write issues one cycle
// after the last beat. The final load beat wins over a same-cycle ALU result,
// which is stalled and must be re-presented.
// Optional feature macro: VWB_BYPASS_EN adds byp_valid/byp_rd/byp_data, a copy
// of the write port for decode-stage forwarding.
module vector_writeback_assembler #(
  parameter int REGSIZE       = 15,
  parameter int VECTORSPERREG = 4,
  parameter int DATAWIDTH     = 16,
  parameter int REGSIZEINT    = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  vector_writeback_assembler_if.slave wb
);

  localparam int CNT_W = (VECTORSPERREG > 1) ? $clog2(VECTORSPERREG) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(VECTORSPERREG - 1);

  typedef logic [VECTORSPERREG-1:0][DATAWIDTH-1:0] vec_t;
  typedef enum logic {IDLE, COLLECT} state_t;

  // Collection stage state
  state_t                state_p0;
  logic [CNT_W-1:0]      cnt_p0;
  vec_t                  buf_p0;
  logic [REGSIZEINT-1:0] ld_rd_p0;

  // Write-port stage state
  logic                  vld_p1;
  logic                  done_p1;
  logic [REGSIZEINT-1:0] rd_p1;
  vec_t                  data_p1;
  logic                  err_q;

  logic collect;
  logic final_beat;
  logic alu_acc;
  vec_t asm_vec;

  function automatic logic idx_ok(input logic [REGSIZEINT-1:0] rd);
    return int'(rd) < REGSIZE;
  endfunction

  // Decode the final load beat, ALU acceptance and the merged load vector
  always_comb begin
    collect    = (state_p0 == COLLECT);
    final_beat = collect & wb.ld_valid & ~wb.ld_abort & (cnt_p0 == LAST_LANE);
    alu_acc    = wb.alu_valid & ~final_beat;
    asm_vec    = buf_p0;
    asm_vec[VECTORSPERREG-1] = wb.ld_data;
  end

  // Load collection FSM, write-port register and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      cnt_p0   <= '0;
      buf_p0   <= '0;
      ld_rd_p0 <= '0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
      rd_p1    <= '0;
      data_p1  <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state_p0)
        IDLE: begin
          if (wb.ld_start) begin
            state_p0 <= COLLECT;
            ld_rd_p0 <= wb.ld_rd;
            cnt_p0   <= '0;
          end
        end
        COLLECT: begin
          if (wb.ld_abort) begin
            state_p0 <= IDLE;
            cnt_p0   <= '0;
          end else if (wb.ld_valid) begin
            buf_p0[cnt_p0] <= wb.ld_data;
            if (cnt_p0 == LAST_LANE) begin
              state_p0 <= IDLE;
              cnt_p0   <= '0;
            end else begin
              cnt_p0 <= cnt_p0 + CNT_W'(1);
            end
          end
        end
      endcase

      // ---- stage p0 -> p1: registered write port ----
      if (final_beat) begin
        vld_p1  <= idx_ok(ld_rd_p0);
        rd_p1   <= ld_rd_p0;
        data_p1 <= asm_vec;
        done_p1 <= 1'b1;
      end else if (alu_acc) begin
        vld_p1  <= idx_ok(wb.alu_rd);
        rd_p1   <= wb.alu_rd;
        data_p1 <= wb.alu_data;
        done_p1 <= 1'b0;
      end else begin
        vld_p1  <= 1'b0;
        done_p1 <= 1'b0;
      end

      if ((collect & wb.ld_start) ||
          (final_beat & ~idx_ok(ld_rd_p0)) ||
          (alu_acc & ~idx_ok(wb.alu_rd)))
        err_q <= 1'b1;
    end
  end

  assign wb.alu_stall = final_beat;
  assign wb.ld_busy   = collect;
  assign wb.ld_done   = done_p1;
  assign wb.err       = err_q;
  assign wb.we3       = vld_p1;
  assign wb.ra3       = rd_p1;
  assign wb.wd3       = data_p1;
`ifdef VWB_BYPASS_EN
  assign wb.byp_valid = vld_p1;
  assign wb.byp_rd    = rd_p1;
  assign wb.byp_data  = data_p1;
`endif

endmodule

// File: tb/tb_vector_writeback_assembler.sv
// Self-checking bench for vector_writeback_assembler. Expected writes are
// queued when their source is driven and compared by a monitor in the cycle
// the write must appear; cycles with nothing due must show we3=0, ld_done=0.
module tb_vector_writeback_assembler;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;

  typedef struct {
    int          due;
    logic        we;
    logic        done;
    logic [3:0]  rd;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];

  vector_writeback_assembler_if #(.REGSIZEINT(4), .VECTORSPERREG(4), .DATAWIDTH(16)) wb ();

  vector_writeback_assembler #(
    .REGSIZE(15), .VECTORSPERREG(4), .DATAWIDTH(16), .REGSIZEINT(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Write-port monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("we3", 64'(wb.we3), 64'(e.we));
        check_eq("ld_done", 64'(wb.ld_done), 64'(e.done));
        if (e.we) begin
          check_eq("ra3", 64'(wb.ra3), 64'(e.rd));
          check_eq("wd3", wb.wd3, e.data);
        end
      end else begin
        check_eq("we3_idle", 64'(wb.we3), 64'd0);
        check_eq("ld_done_idle", 64'(wb.ld_done), 64'd0);
      end
`ifdef VWB_BYPASS_EN
      check_eq("byp_valid", 64'(wb.byp_valid), 64'(wb.we3 & (exp_q.size() >= 0)));
`endif
    end
  end

  task automatic idle_inputs();
    wb.alu_valid = 1'b0;
    wb.alu_rd    = '0;
    wb.alu_data  = '0;
    wb.ld_start  = 1'b0;
    wb.ld_rd     = '0;
    wb.ld_valid  = 1'b0;
    wb.ld_data   = '0;
    wb.ld_abort  = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic we, input logic done, input logic [3:0] rd,
                          input logic [63:0] data);
    exp_t e;
    e.due  = cyc + 1;
    e.we   = we;
    e.done = done;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Four lane beats (lane 0 first); the final beat queues the expected write
  task automatic load_beats(input logic [3:0] rd, input logic [63:0] lanes, input logic exp_we);
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      wb.ld_valid = 1'b1;
      wb.ld_data  = lanes[i*16 +: 16];
      if (i == 0) check_eq("ld_busy_collect", 64'(wb.ld_busy), 64'd1);
      if (i == 3) push_exp(exp_we, 1'b1, rd, lanes);
      tick();
    end
    idle_inputs();
    check_eq("ld_busy_after", 64'(wb.ld_busy), 64'd0);
  endtask

  task automatic run_load(input logic [3:0] rd, input logic [63:0] lanes, input logic exp_we);
    idle_inputs();
    wb.ld_start = 1'b1;
    wb.ld_rd    = rd;
    tick();
    load_beats(rd, lanes, exp_we);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    #1;
    check_eq("rst_we3", 64'(wb.we3), 64'd0);
    check_eq("rst_ra3", 64'(wb.ra3), 64'd0);
    check_eq("rst_wd3", wb.wd3, 64'd0);
    check_eq("rst_ld_done", 64'(wb.ld_done), 64'd0);
    check_eq("rst_err", 64'(wb.err), 64'd0);
    check_eq("rst_alu_stall", 64'(wb.alu_stall), 64'd0);
    check_eq("rst_ld_busy", 64'(wb.ld_busy), 64'd0);
    rst_n = 1'b1;
    tick();

    // ALU write to r3
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 4'd3;
    wb.alu_data  = {16'd4, 16'd3, 16'd2, 16'd1};
    #1 check_eq("alu_stall_alone", 64'(wb.alu_stall), 64'd0);
    push_exp(1'b1, 1'b0, 4'd3, {16'd4, 16'd3, 16'd2, 16'd1});
    tick();
    idle_inputs();
    tick();

    // Plain load to r5
    run_load(4'd5, {16'h0044, 16'h0033, 16'h0022, 16'h0011}, 1'b1);
    tick();

    // Collision: final beat of load to r9 against ALU r2, then back-to-back load r6
    idle_inputs();
    wb.ld_start = 1'b1;
    wb.ld_rd    = 4'd9;
    tick();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      wb.ld_valid = 1'b1;
      wb.ld_data  = 16'h0090 + 16'(i);
      tick();
    end
    idle_inputs();
    wb.ld_valid  = 1'b1;
    wb.ld_data   = 16'h0093;
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 4'd2;
    wb.alu_data  = 64'hBEEF_0000_CAFE_1234;
    #1 check_eq("alu_stall_collide", 64'(wb.alu_stall), 64'd1);
    push_exp(1'b1, 1'b1, 4'd9, {16'h0093, 16'h0092, 16'h0091, 16'h0090});
    tick();
    wb.ld_valid = 1'b0;
    wb.ld_data  = '0;
    wb.ld_start = 1'b1;
    wb.ld_rd    = 4'd6;
    #1 check_eq("alu_stall_retry", 64'(wb.alu_stall), 64'd0);
    push_exp(1'b1, 1'b0, 4'd2, 64'hBEEF_0000_CAFE_1234);
    tick();
    load_beats(4'd6, {16'h6666, 16'h5555, 16'h4444, 16'h3333}, 1'b1);
    tick();
    check_eq("err_clean", 64'(wb.err), 64'd0);

    // Abort load to r7 after two beats (abort beats a same-cycle lane)
    idle_inputs();
    wb.ld_start = 1'b1;
    wb.ld_rd    = 4'd7;
    tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h00A1; tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h00A2; tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h00A3; wb.ld_abort = 1'b1; tick();
    idle_inputs();
    check_eq("abort_busy", 64'(wb.ld_busy), 64'd0);
    wb.ld_valid = 1'b1;
    wb.ld_data  = 16'h00EE;
    tick();
    idle_inputs();
    check_eq("idle_beat_busy", 64'(wb.ld_busy), 64'd0);
    run_load(4'd7, {16'h0074, 16'h0073, 16'h0072, 16'h0071}, 1'b1);
    tick();

    // Index error: ALU to r15, then load to r15
    wb.alu_valid = 1'b1;
    wb.alu_rd    = 4'd15;
    wb.alu_data  = 64'h1111_2222_3333_4444;
    push_exp(1'b0, 1'b0, 4'd15, 64'h0);
    tick();
    idle_inputs();
    check_eq("err_alu_idx", 64'(wb.err), 64'd1);
    repeat (3) tick();
    check_eq("err_sticky", 64'(wb.err), 64'd1);
    run_load(4'd15, {16'h0F04, 16'h0F03, 16'h0F02, 16'h0F01}, 1'b0);
    tick();

    // Reset mid-collection: two beats of a load to r4, then reset
    wb.ld_start = 1'b1;
    wb.ld_rd    = 4'd4;
    tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'hDEAD; tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'hBEEF; tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_we3", 64'(wb.we3), 64'd0);
    check_eq("midrst_ra3", 64'(wb.ra3), 64'd0);
    check_eq("midrst_wd3", wb.wd3, 64'd0);
    check_eq("midrst_busy", 64'(wb.ld_busy), 64'd0);
    check_eq("midrst_err", 64'(wb.err), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_load(4'd4, {16'h0404, 16'h0403, 16'h0402, 16'h0401}, 1'b1);
    tick();
    check_eq("err_after_rst", 64'(wb.err), 64'd0);

    // ld_start during collection is ignored and flags an error
    wb.ld_start = 1'b1;
    wb.ld_rd    = 4'd1;
    tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h0101; tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h0102;
    wb.ld_start = 1'b1; wb.ld_rd = 4'd8; tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h0103; tick();
    idle_inputs(); wb.ld_valid = 1'b1; wb.ld_data = 16'h0104;
    push_exp(1'b1, 1'b1, 4'd1, {16'h0104, 16'h0103, 16'h0102, 16'h0101});
    tick();
    idle_inputs();
    check_eq("err_start_collect", 64'(wb.err), 64'd1);

    repeat (3) tick();
    check_eq("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
